// File: rtl/tlb_channel_arbiter.sv
// Round-robin arbiter sharing one TileLink B channel among NUM_REQ requesters, with burst locking and stall hold.
// Optional protocol checker enabled by defining TLB_ARB_PROTOCOL_CHECK_EN; otherwise err is tied low.
module tlb_channel_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_SIZE = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_opcode,
    input  logic [2*NUM_REQ-1:0]  req_param,
    input  logic [4*NUM_REQ-1:0]  req_size,
    input  logic [NUM_REQ-1:0]    req_source,
    input  logic [32*NUM_REQ-1:0] req_address,
    input  logic [4*NUM_REQ-1:0]  req_mask,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_corrupt,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [2:0]            b_opcode,
    output logic [1:0]            b_param,
    output logic [3:0]            b_size,
    output logic                  b_source,
    output logic [31:0]           b_address,
    output logic [3:0]            b_mask,
    output logic [31:0]           b_data,
    output logic                  b_corrupt,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t      state_r, state_n;
    logic [1:0]  ptr_r, ptr_n;
    logic [1:0]  owner_r, owner_n;
    logic [3:0]  cnt_r, cnt_n;
    logic [1:0]  winner_s;
    logic        found_s;
    logic [1:0]  sel_s;
    logic [4:0]  beats_s;
    logic        fire_s;

    // Data opcodes (0..3) span size-2 power-of-two beats; oversize requests are clamped.
    function automatic logic [4:0] beats_of(input logic [2:0] opcode, input logic [3:0] size);
        logic [3:0] sz;
        sz = (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
        beats_of = ((opcode <= 3'd3) && (sz > 4'd2)) ? (5'd1 << (sz - 4'd2)) : 5'd1;
    endfunction

    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
        return 2'(s);
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'(NUM_REQ - 1)) ? 2'd0 : (idx + 2'd1);
    endfunction

    // Rotating-priority scan: first valid requester at or after ptr.
    always_comb begin
        winner_s = ptr_r;
        found_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                winner_s = (!found_s && (wrap_idx(ptr_r, k) == 2'(i)) && req_valid[i]) ? 2'(i) : winner_s;
                found_s  = found_s | ((wrap_idx(ptr_r, k) == 2'(i)) & req_valid[i]);
            end
        end
    end

    // Arbitration is only open in IDLE; otherwise the locked owner drives the channel.
    assign sel_s    = (state_r == ST_IDLE) ? winner_s : owner_r;
    assign grant_id = sel_s;
    assign busy     = (state_r != ST_IDLE);
    assign fire_s   = b_valid & b_ready;
    assign beats_s  = beats_of(b_opcode, b_size);

    // Field mux of the selected requester onto the B channel.
    always_comb begin
        b_valid   = 1'b0;
        b_opcode  = 3'd0;
        b_param   = 2'd0;
        b_size    = 4'd0;
        b_source  = 1'b0;
        b_address = 32'd0;
        b_mask    = 4'd0;
        b_data    = 32'd0;
        b_corrupt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            b_valid   = (sel_s == 2'(i)) ? req_valid[i]            : b_valid;
            b_opcode  = (sel_s == 2'(i)) ? req_opcode[3*i +: 3]    : b_opcode;
            b_param   = (sel_s == 2'(i)) ? req_param[2*i +: 2]     : b_param;
            b_size    = (sel_s == 2'(i)) ? req_size[4*i +: 4]      : b_size;
            b_source  = (sel_s == 2'(i)) ? req_source[i]           : b_source;
            b_address = (sel_s == 2'(i)) ? req_address[32*i +: 32] : b_address;
            b_mask    = (sel_s == 2'(i)) ? req_mask[4*i +: 4]      : b_mask;
            b_data    = (sel_s == 2'(i)) ? req_data[32*i +: 32]    : b_data;
            b_corrupt = (sel_s == 2'(i)) ? req_corrupt[i]          : b_corrupt;
        end
    end

    // Ready is returned only to the selected requester, and only while it presents a beat.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (sel_s == 2'(i)) & b_valid & b_ready;
        end
    end

    // Grant FSM next-state: cnt holds beats remaining after the current one, minus one.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        owner_n = owner_r;
        cnt_n   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) begin
                    if (beats_s == 5'd1) begin
                        ptr_n = next_idx(winner_s);
                    end else begin
                        state_n = ST_BURST;
                        owner_n = winner_s;
                        cnt_n   = 4'(beats_s - 5'd2);
                    end
                end else if (b_valid) begin
                    state_n = ST_HOLD;
                    owner_n = winner_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (fire_s) begin
                    if (beats_s == 5'd1) begin
                        state_n = ST_IDLE;
                        ptr_n   = next_idx(owner_r);
                    end else begin
                        state_n = ST_BURST;
                        cnt_n   = 4'(beats_s - 5'd2);
                    end
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_BURST: begin
                if (fire_s) begin
                    if (cnt_r == 4'd0) begin
                        state_n = ST_IDLE;
                        ptr_n   = next_idx(owner_r);
                    end else begin
                        cnt_n = cnt_r - 4'd1;
                    end
                end else begin
                    state_n = ST_BURST;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Grant FSM state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            owner_r <= 2'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            owner_r <= owner_n;
            cnt_r   <= cnt_n;
        end
    end

`ifdef TLB_ARB_PROTOCOL_CHECK_EN
    logic [2:0]  held_opcode_r;
    logic [3:0]  held_size_r;
    logic [31:0] held_address_r;
    logic        err_r;
    logic        bad_msg_s;
    logic        bad_hold_s;

    assign bad_msg_s  = b_valid & ((b_size > 4'(MAX_SIZE)) | (b_opcode == 3'd7));
    assign bad_hold_s = (state_r == ST_HOLD) &
                        (!b_valid | (b_opcode != held_opcode_r) | (b_size != held_size_r) |
                         (b_address != held_address_r));

    // Sticky error plus snapshot of the stalled message taken on entry to HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r          <= 1'b0;
            held_opcode_r  <= 3'd0;
            held_size_r    <= 4'd0;
            held_address_r <= 32'd0;
        end else begin
            err_r <= err_r | bad_msg_s | bad_hold_s;
            if ((state_r == ST_IDLE) && b_valid && !b_ready) begin
                held_opcode_r  <= b_opcode;
                held_size_r    <= b_size;
                held_address_r <= b_address;
            end else begin
                held_opcode_r  <= held_opcode_r;
                held_size_r    <= held_size_r;
                held_address_r <= held_address_r;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_channel_arbiter.sv
// Bench for tlb_channel_arbiter: a 2-requester and a 4-requester instance share stimulus and are
// checked every cycle against a message-level model, plus literal expectations from directed scenarios.
module tb_tlb_channel_arbiter;

`ifdef TLB_ARB_PROTOCOL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clock;
    logic        rst;
    logic        br;
    logic [3:0]  vv;
    logic [2:0]  op   [4];
    logic [1:0]  par  [4];
    logic [3:0]  sz   [4];
    logic        src  [4];
    logic [31:0] addr [4];
    logic [3:0]  msk  [4];
    logic [31:0] dat  [4];
    logic        cor  [4];

    logic [11:0]  pk_op;
    logic [7:0]   pk_par;
    logic [15:0]  pk_sz;
    logic [3:0]   pk_src;
    logic [127:0] pk_addr;
    logic [15:0]  pk_msk;
    logic [127:0] pk_dat;
    logic [3:0]   pk_cor;

    logic        o_bv   [2];
    logic [3:0]  o_rdy  [2];
    logic [1:0]  rdy2;
    logic [2:0]  o_op   [2];
    logic [1:0]  o_par  [2];
    logic [3:0]  o_sz   [2];
    logic        o_src  [2];
    logic [31:0] o_addr [2];
    logic [3:0]  o_msk  [2];
    logic [31:0] o_dat  [2];
    logic        o_cor  [2];
    logic [1:0]  o_gnt  [2];
    logic        o_busy [2];
    logic        o_err  [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pk_op[3*i +: 3]    = op[i];
            pk_par[2*i +: 2]   = par[i];
            pk_sz[4*i +: 4]    = sz[i];
            pk_src[i]          = src[i];
            pk_addr[32*i +: 32] = addr[i];
            pk_msk[4*i +: 4]   = msk[i];
            pk_dat[32*i +: 32] = dat[i];
            pk_cor[i]          = cor[i];
        end
    end

    assign o_rdy[0] = {2'b00, rdy2};

    tlb_channel_arbiter #(.NUM_REQ(2), .MAX_SIZE(6)) u_dut2 (
        .clock(clock), .reset(rst),
        .req_valid(vv[1:0]), .req_ready(rdy2),
        .req_opcode(pk_op[5:0]), .req_param(pk_par[3:0]), .req_size(pk_sz[7:0]),
        .req_source(pk_src[1:0]), .req_address(pk_addr[63:0]), .req_mask(pk_msk[7:0]),
        .req_data(pk_dat[63:0]), .req_corrupt(pk_cor[1:0]),
        .b_valid(o_bv[0]), .b_ready(br),
        .b_opcode(o_op[0]), .b_param(o_par[0]), .b_size(o_sz[0]), .b_source(o_src[0]),
        .b_address(o_addr[0]), .b_mask(o_msk[0]), .b_data(o_dat[0]), .b_corrupt(o_cor[0]),
        .grant_id(o_gnt[0]), .busy(o_busy[0]), .err(o_err[0])
    );

    tlb_channel_arbiter #(.NUM_REQ(4), .MAX_SIZE(6)) u_dut4 (
        .clock(clock), .reset(rst),
        .req_valid(vv), .req_ready(o_rdy[1]),
        .req_opcode(pk_op), .req_param(pk_par), .req_size(pk_sz),
        .req_source(pk_src), .req_address(pk_addr), .req_mask(pk_msk),
        .req_data(pk_dat), .req_corrupt(pk_cor),
        .b_valid(o_bv[1]), .b_ready(br),
        .b_opcode(o_op[1]), .b_param(o_par[1]), .b_size(o_sz[1]), .b_source(o_src[1]),
        .b_address(o_addr[1]), .b_mask(o_msk[1]), .b_data(o_dat[1]), .b_corrupt(o_cor[1]),
        .grant_id(o_gnt[1]), .busy(o_busy[1]), .err(o_err[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Message-level model: an optional locked owner with beats left, plus the rotation pointer.
    bit          m_lock  [2];
    int          m_owner [2];
    int          m_left  [2];
    int          m_ptr   [2];
    bit          m_err   [2];
    bit          m_stall [2];
    logic [2:0]  m_cop   [2];
    logic [3:0]  m_csz   [2];
    logic [31:0] m_cad   [2];

    function automatic int beats_m(input logic [2:0] o, input logic [3:0] s);
        int e;
        e = (s > 4'd6) ? 6 : int'(s);
        if (o <= 3'd3 && e > 2) return 1 << (e - 2);
        return 1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_ptr[k] = 0;
            m_err[k] = 0; m_stall[k] = 0; m_cop[k] = 3'd0; m_csz[k] = 4'd0; m_cad[k] = 32'd0;
        end
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                int n;
                int sel;
                bit found;
                bit ev;
                logic [3:0] er;
                n = (k == 0) ? 2 : 4;
                sel = 0;
                found = 0;
                if (m_lock[k]) begin
                    sel = m_owner[k];
                    ev = vv[sel];
                end else begin
                    for (int s = 0; s < n; s++) begin
                        int i;
                        i = (m_ptr[k] + s) % n;
                        if (!found && vv[i]) begin
                            found = 1;
                            sel = i;
                        end
                    end
                    ev = found;
                end
                er = 4'd0;
                if (ev && br) er[sel] = 1'b1;
                if (cmp_en) begin
                    chk($sformatf("b_valid[%0d]", k), 96'(o_bv[k]), 96'(ev));
                    chk($sformatf("req_ready[%0d]", k), 96'(o_rdy[k]), 96'(er));
                    chk($sformatf("busy[%0d]", k), 96'(o_busy[k]), 96'(m_lock[k]));
                    chk($sformatf("err[%0d]", k), 96'(o_err[k]), 96'(m_err[k]));
                    if (ev) begin
                        chk($sformatf("grant_id[%0d]", k), 96'(o_gnt[k]), 96'(sel));
                        chk($sformatf("b_fields[%0d]", k),
                            96'({o_op[k], o_par[k], o_sz[k], o_src[k], o_addr[k], o_msk[k], o_dat[k], o_cor[k]}),
                            96'({op[sel], par[sel], sz[sel], src[sel], addr[sel], msk[sel], dat[sel], cor[sel]}));
                    end
                end
                if (rst) begin
                    m_lock[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_ptr[k] = 0;
                    m_err[k] = 0; m_stall[k] = 0;
                end else begin
                    if (CHK_EN) begin
                        if (ev && (sz[sel] > 4'd6 || op[sel] == 3'd7)) m_err[k] = 1;
                        if (m_stall[k] && (!vv[m_owner[k]] || op[m_owner[k]] != m_cop[k] ||
                            sz[m_owner[k]] != m_csz[k] || addr[m_owner[k]] != m_cad[k])) m_err[k] = 1;
                    end
                    if (!m_lock[k]) begin
                        if (ev && br) begin
                            if (beats_m(op[sel], sz[sel]) == 1) begin
                                m_ptr[k] = (sel + 1) % n;
                            end else begin
                                m_lock[k] = 1; m_owner[k] = sel; m_stall[k] = 0;
                                m_left[k] = beats_m(op[sel], sz[sel]) - 1;
                            end
                        end else if (ev) begin
                            m_lock[k] = 1; m_owner[k] = sel; m_stall[k] = 1;
                            m_left[k] = beats_m(op[sel], sz[sel]);
                            m_cop[k] = op[sel]; m_csz[k] = sz[sel]; m_cad[k] = addr[sel];
                        end
                    end else if (ev && br) begin
                        m_stall[k] = 0;
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) begin
                            m_lock[k] = 0;
                            m_ptr[k] = (m_owner[k] + 1) % n;
                        end
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [2:0] o, input logic [3:0] s, input logic [31:0] a);
        op[i] = o; sz[i] = s; addr[i] = a;
        par[i] = 2'(i); src[i] = 1'(i); msk[i] = 4'hF;
        dat[i] = a ^ 32'h5A5A_5A5A; cor[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; br = 1'b0; vv = 4'd0;
        for (int i = 0; i < 4; i++) set_req(i, 3'd6, 4'd2, 32'h0);
        nxt(); nxt();
        rst = 1'b0; cmp_en = 1'b1;
        smp();
        for (int k = 0; k < 2; k++) begin
            chk("rst_b_valid", 96'(o_bv[k]), 96'd0);
            chk("rst_ready", 96'(o_rdy[k]), 96'd0);
            chk("rst_busy", 96'(o_busy[k]), 96'd0);
            chk("rst_err", 96'(o_err[k]), 96'd0);
        end
        nxt();

        // Two probes every cycle: grants alternate, one fire per cycle.
        set_req(0, 3'd6, 4'd2, 32'h1000); set_req(1, 3'd6, 4'd2, 32'h2000);
        vv = 4'b0011; br = 1'b1;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk("alt_grant2", 96'(o_gnt[0]), 96'(c % 2));
            chk("alt_grant4", 96'(o_gnt[1]), 96'(c % 2));
            nxt();
        end

        // 4-beat PutFullData from req0 is never interleaved; req1 follows on cycle 5.
        set_req(0, 3'd0, 4'd4, 32'h3000);
        for (int c = 0; c < 5; c++) begin
            dat[0] = 32'hA000_0000 + 32'(c);
            smp();
            chk("burst_grant2", 96'(o_gnt[0]), 96'((c < 4) ? 0 : 1));
            chk("burst_grant4", 96'(o_gnt[1]), 96'((c < 4) ? 0 : 1));
            chk("burst_busy2", 96'(o_busy[0]), 96'((c >= 1 && c < 4) ? 1 : 0));
            nxt();
        end
        vv = 4'd0;

        // Stalled req1 holds the channel even after req0 asserts.
        set_req(0, 3'd6, 4'd2, 32'h4000); set_req(1, 3'd5, 4'd2, 32'h5000);
        vv = 4'b0010; br = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) vv = 4'b0011;
            smp();
            chk("hold_grant2", 96'(o_gnt[0]), 96'd1);
            chk("hold_grant4", 96'(o_gnt[1]), 96'd1);
            chk("hold_bvalid", 96'(o_bv[0]), 96'd1);
            chk("hold_busy", 96'(o_busy[1]), 96'((c > 0) ? 1 : 0));
            nxt();
        end
        br = 1'b1;
        smp();
        chk("hold_fire_ready2", 96'(rdy2), 96'h2);
        nxt();
        vv = 4'b0001;
        smp();
        chk("after_hold_grant2", 96'(o_gnt[0]), 96'd0);
        chk("after_hold_grant4", 96'(o_gnt[1]), 96'd0);
        nxt();
        vv = 4'd0;

        // Reset after two beats of an 8-beat burst; a new Get fires at once.
        set_req(0, 3'd0, 4'd5, 32'h6000);
        vv = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            smp();
            chk("pre_rst_grant", 96'(o_gnt[0]), 96'd0);
            nxt();
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        set_req(0, 3'd4, 4'd2, 32'h7000); set_req(1, 3'd6, 4'd2, 32'h8000);
        vv = 4'b0011;
        smp();
        chk("post_rst_grant2", 96'(o_gnt[0]), 96'd0);
        chk("post_rst_grant4", 96'(o_gnt[1]), 96'd0);
        chk("post_rst_busy", 96'(o_busy[0]), 96'd0);
        chk("post_rst_op", 96'(o_op[0]), 96'd4);
        chk("post_rst_ready4", 96'(o_rdy[1]), 96'h1);
        nxt();
        vv = 4'b0010;
        smp();
        chk("post_get_grant", 96'(o_gnt[1]), 96'd1);
        nxt();
        vv = 4'd0;

        // Oversized PutPartialData: clamped to 16 beats; err sticky when checking is built.
        set_req(0, 3'd1, 4'd7, 32'h9000);
        vv = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            smp();
            chk("big_grant", 96'(o_gnt[0]), 96'd0);
            chk("big_busy", 96'(o_busy[1]), 96'((c > 0) ? 1 : 0));
            if (c >= 1) chk("big_err", 96'(o_err[0]), 96'(CHK_EN));
            nxt();
        end
        vv = 4'd0;
        smp();
        chk("big_done_busy", 96'(o_busy[0]), 96'd0);
        chk("big_err_sticky", 96'(o_err[1]), 96'(CHK_EN));
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        smp();
        chk("err_cleared", 96'(o_err[0]), 96'd0);
        nxt();

        // Four-requester rotation from ptr=2 with only req3 and req1 valid.
        set_req(1, 3'd6, 4'd2, 32'hA000); set_req(3, 3'd6, 4'd2, 32'hB000);
        vv = 4'b0010;
        smp();
        chk("p2_setup", 96'(o_gnt[1]), 96'd1);
        nxt();
        vv = 4'b1010;
        smp();
        chk("p2_first", 96'(o_gnt[1]), 96'd3);
        nxt();
        smp();
        chk("p2_second", 96'(o_gnt[1]), 96'd1);
        nxt();
        vv = 4'd0;

        // Mixed traffic with stalls and valid drops; fields fixed per requester.
        set_req(0, 3'd0, 4'd3, 32'hC000); set_req(1, 3'd6, 4'd2, 32'hD000);
        set_req(2, 3'd4, 4'd2, 32'hE000); set_req(3, 3'd2, 4'd4, 32'hF000);
        for (int c = 0; c < 150; c++) begin
            vv = 4'($urandom_range(0, 15));
            br = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) dat[i] = $urandom;
            smp();
            nxt();
        end
        vv = 4'd0;
        smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
